branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/control_types_pkg.sv | 21 ++
 rtl/bp_sat_counter.sv | 19 +
 rtl/branch_predictor.sv | 97 +++++++++
 tb/tb_branch_predictor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/control_types_pkg.sv
// Shared control-path types: branch comparison opcodes and the 2-bit
// branch-predictor counter encoding.
package control_types;

    typedef enum logic [2:0] {
        COMP_EQ  = 3'd0,
        COMP_NE  = 3'd1,
        COMP_LT  = 3'd2,
        COMP_GE  = 3'd3,
        COMP_LTU = 3'd4,
        COMP_GEU = 3'd5
    } comp_op_t;

    typedef logic [1:0] bp_cnt_t;

    localparam bp_cnt_t BP_STRONG_NT = 2'b00;
    localparam bp_cnt_t BP_WEAK_NT   = 2'b01;
    localparam bp_cnt_t BP_WEAK_T    = 2'b10;
    localparam bp_cnt_t BP_STRONG_T  = 2'b11;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for one 2-bit saturating branch counter.
module bp_sat_counter
    import control_types::*;
(
    input  bp_cnt_t state,
    input  logic    taken,
    output bp_cnt_t next_state
);

    always_comb begin
        next_state = state;
        if (taken) begin
            if (state != BP_STRONG_T) next_state = state + 2'd1;
        end else begin
            if (state != BP_STRONG_NT) next_state = state - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal 2-bit branch predictor with resolve-time update and statistics.
// Define BP_GSHARE_EN to XOR a global history register into the table index.
module branch_predictor
    import control_types::*;
#(
    parameter int IDX_BITS = 6,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         lookup_pc,
    output logic                pred_taken,
    output logic [IDX_BITS-1:0] pred_idx,
    input  logic                upd_valid,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_taken,
    input  logic                upd_pred,
    output logic                mispredict,
    output logic [CNT_W-1:0]    br_count,
    output logic [CNT_W-1:0]    mispred_count
);

    localparam int N = 1 << IDX_BITS;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    bp_cnt_t             tbl [N];
    bp_cnt_t             upd_cur;
    bp_cnt_t             upd_next;
    logic [IDX_BITS-1:0] lk_idx;
    logic                mispred_p0;
    logic                mispred_p1;
    logic [CNT_W-1:0]    br_cnt_p1;
    logic [CNT_W-1:0]    mis_cnt_p1;
    logic                unused_pc;

    assign unused_pc = ^{lookup_pc[31:IDX_BITS+2], lookup_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [IDX_BITS-1:0] ghr;

    // History is updated only at resolve time, so lookups never see wrong-path outcomes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (upd_valid) begin
            ghr <= {ghr[IDX_BITS-2:0], upd_taken};
        end
    end

    assign lk_idx = lookup_pc[IDX_BITS+1:2] ^ ghr;
`else
    assign lk_idx = lookup_pc[IDX_BITS+1:2];
`endif

    // Lookup reads the registered table, so a same-cycle update is seen next cycle.
    assign pred_idx   = lk_idx;
    assign pred_taken = tbl[lk_idx][1];

    assign upd_cur = tbl[upd_idx];

    bp_sat_counter u_sat (
        .state      (upd_cur),
        .taken      (upd_taken),
        .next_state (upd_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) tbl[i] <= BP_WEAK_NT;
        end else if (upd_valid) begin
            tbl[upd_idx] <= upd_next;
        end
    end

    assign mispred_p0 = upd_valid & (upd_taken != upd_pred);

    // Stage p1: registered mispredict pulse and saturating statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispred_p1 <= 1'b0;
            br_cnt_p1  <= '0;
            mis_cnt_p1 <= '0;
        end else begin
            mispred_p1 <= mispred_p0;
            if (upd_valid)  br_cnt_p1  <= sat_inc(br_cnt_p1);
            if (mispred_p0) mis_cnt_p1 <= sat_inc(mis_cnt_p1);
        end
    end

    assign mispredict    = mispred_p1;
    assign br_count      = br_cnt_p1;
    assign mispred_count = mis_cnt_p1;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a queue-based expected stream checked
// by a separate negedge monitor, plus directed scenarios against constants.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] lookup_pc;
    logic        pred_taken, pred_taken4;
    logic [5:0]  pred_idx, pred_idx4;
    logic        upd_valid;
    logic [5:0]  upd_idx;
    logic        upd_taken;
    logic        upd_pred;
    logic        mispredict, mispredict4;
    logic [31:0] br_count, mispred_count;
    logic [3:0]  br_count4, mispred_count4;

    always #5 clk = ~clk;

    branch_predictor #(.IDX_BITS(6), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc),
        .pred_taken(pred_taken), .pred_idx(pred_idx),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_pred(upd_pred), .mispredict(mispredict),
        .br_count(br_count), .mispred_count(mispred_count)
    );

    // Narrow-counter copy makes statistics saturation reachable in a short run.
    branch_predictor #(.IDX_BITS(6), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc),
        .pred_taken(pred_taken4), .pred_idx(pred_idx4),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_pred(upd_pred), .mispredict(mispredict4),
        .br_count(br_count4), .mispred_count(mispred_count4)
    );

    typedef struct {
        logic        pt;
        logic [5:0]  pi;
        logic        mp;
        logic [31:0] bc;
        logic [31:0] mc;
        logic [3:0]  bc4;
        logic [3:0]  mc4;
    } exp_t;

    exp_t   expq[$];
    int     n_total = 0;
    int     n_pass  = 0;

    // Reference model: plain integers, counters in 0..3, totals unbounded.
    int     m_cnt[64];
    int     m_ghr;
    logic   m_mp;
    longint m_bc, m_mc;

    function automatic longint min_l(input longint a, input longint b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_cnt[i] = 1;
        m_ghr = 0;
        m_mp  = 1'b0;
        m_bc  = 0;
        m_mc  = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    task automatic cycle(input logic [31:0] pc, input logic v, input logic [5:0] idx,
                         input logic t, input logic p);
        exp_t e;
        int   li;
        @(posedge clk);
        #1;
        lookup_pc = pc;
        upd_valid = v;
        upd_idx   = idx;
        upd_taken = t;
        upd_pred  = p;
        li   = ((pc >> 2) & 63) ^ m_ghr;
        e.pt = (m_cnt[li] >= 2);
        e.pi = li[5:0];
        e.mp = m_mp;
        e.bc = 32'(min_l(m_bc, 64'hFFFF_FFFF));
        e.mc = 32'(min_l(m_mc, 64'hFFFF_FFFF));
        e.bc4 = 4'(min_l(m_bc, 15));
        e.mc4 = 4'(min_l(m_mc, 15));
        expq.push_back(e);
        m_mp = v && (t != p);
        if (v) begin
            m_bc++;
            if (t != p) m_mc++;
            if (t) m_cnt[idx] = (m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1;
            else   m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
`ifdef BP_GSHARE_EN
            m_ghr = ((m_ghr << 1) | int'(t)) & 63;
`endif
        end
    endtask

    task automatic idle(input logic [31:0] pc);
        cycle(pc, 1'b0, 6'd0, $urandom_range(0, 1), $urandom_range(0, 1));
    endtask

    // Monitor: every issued cycle presents outputs once, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && expq.size() > 0) begin
                e = expq.pop_front();
                chk("sb_pred_taken",   {31'd0, pred_taken},   {31'd0, e.pt});
                chk("sb_pred_idx",     {26'd0, pred_idx},     {26'd0, e.pi});
                chk("sb_mispredict",   {31'd0, mispredict},   {31'd0, e.mp});
                chk("sb_br_count",     br_count,              e.bc);
                chk("sb_mispred_count", mispred_count,        e.mc);
                chk("sb_br_count4",    {28'd0, br_count4},    {28'd0, e.bc4});
                chk("sb_mispred_count4", {28'd0, mispred_count4}, {28'd0, e.mc4});
            end
        end
    end

    task automatic drain();
        int budget;
        budget = 20;
        while (expq.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        @(negedge clk);
        chk("drain_queue_empty", expq.size(), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        lookup_pc = 32'h100;
        upd_valid = 1'b1;
        upd_idx   = 6'd0;
        upd_taken = 1'b1;
        upd_pred  = 1'b0;
        model_reset();
        #12 upd_valid = 1'b0;
        #10 rst_n = 1'b1;

        // Post-reset state; the update held during reset must have been dropped.
        idle(32'h100);
        @(negedge clk);
        chk("rst_pred_taken",    {31'd0, pred_taken}, 32'd0);
        chk("rst_br_count",      br_count, 32'd0);
        chk("rst_mispred_count", mispred_count, 32'd0);

        // Two taken-but-predicted-NT updates at 0x100's index.
        cycle(32'h100, 1'b1, 6'h00, 1'b1, 1'b0);
        @(negedge clk);
        chk("two_upd_pulse1", {31'd0, mispredict}, 32'd0);
        cycle(32'h100, 1'b1, 6'h00, 1'b1, 1'b0);
        @(negedge clk);
        chk("two_upd_pulse_a", {31'd0, mispredict}, 32'd1);
        idle(32'h100);
        @(negedge clk);
        chk("two_upd_pulse_b",    {31'd0, mispredict}, 32'd1);
        chk("two_upd_pred",       {31'd0, pred_taken}, 32'd1);
        chk("two_upd_mispred_cnt", mispred_count, 32'd2);
        idle(32'h100);
        @(negedge clk);
        chk("two_upd_pulse_end", {31'd0, mispredict}, 32'd0);

        // Saturate index 0x10 at strong-T, then one not-taken leaves weak-T.
        for (int i = 0; i < 4; i++) cycle(32'h140, 1'b1, 6'h10, 1'b1, 1'b1);
        cycle(32'h140, 1'b1, 6'h10, 1'b0, 1'b1);
        idle(32'h140);
        @(negedge clk);
        chk("sat_hi_then_nt_pred", {31'd0, pred_taken}, 32'd1);
        cycle(32'h140, 1'b1, 6'h10, 1'b0, 1'b1);
        idle(32'h140);
        @(negedge clk);
        chk("sat_second_nt_pred", {31'd0, pred_taken}, 32'd0);

        // Same-cycle lookup and update at a weak-NT index.
        cycle(32'h180, 1'b1, 6'h20, 1'b1, 1'b0);
        @(negedge clk);
        chk("bypass_same_cycle", {31'd0, pred_taken}, 32'd0);
        idle(32'h180);
        @(negedge clk);
        chk("bypass_next_cycle", {31'd0, pred_taken}, 32'd1);

        // Randomized traffic over a narrow index range to force collisions.
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 15)) << 2),
                  ($urandom_range(0, 9) < 7), 6'($urandom_range(0, 15)),
                  $urandom_range(0, 1), $urandom_range(0, 1));
        end
        idle(32'h100);
        idle(32'h100);
        drain();
        chk("narrow_br_count_sat",      {28'd0, br_count4},      32'hF);
        chk("narrow_mispred_count_sat", {28'd0, mispred_count4}, 32'hF);
        chk("wide_br_count_total",      br_count, 32'(m_bc));

        // Asynchronous reset mid-cycle, with no clock edge in between.
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_br_count",   br_count, 32'd0);
        chk("async_rst_mispred",    mispred_count, 32'd0);
        chk("async_rst_br_count4",  {28'd0, br_count4}, 32'd0);
        chk("async_rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

`ifdef BP_GSHARE_EN
        cycle(32'h200, 1'b1, 6'h01, 1'b1, 1'b1);
        cycle(32'h200, 1'b1, 6'h02, 1'b1, 1'b1);
        cycle(32'h200, 1'b1, 6'h03, 1'b0, 1'b0);
        idle(32'h100);
        @(negedge clk);
        chk("gshare_pred_idx", {26'd0, pred_idx}, 32'h06);
`endif
        idle(32'h100);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
